// File: rtl/rr_arb16.sv
// 16-way round-robin arbiter: IDLE/GRANT FSM, one grant at a time, released by done.
// Define ARB_TIMEOUT_EN to add a hold counter that force-releases a grant after MAX_HOLD cycles.
module rr_arb16 #(
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        busy,
    output logic        timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (MAX_HOLD < 1) begin : g_max_hold_check
        $error("rr_arb16: MAX_HOLD must be at least 1");
    end

    logic [0:0]  state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic [3:0]  sel_idx;
    logic        sel_found;
    logic        hold_expired;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        sel_idx   = ptr_q;
        sel_found = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (req[ptr_q + 4'(k)]) begin
                sel_idx   = ptr_q + 4'(k);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_GRANT;
                    idx_d   = sel_idx;
                    grant_d = 16'h0001 << sel_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (done || hold_expired) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = idx_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = busy_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 255) ? $clog2(MAX_HOLD + 1) : 8;

    logic [CW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    assign hold_expired = (state_q == ST_GRANT) && (hold_q == CW'(MAX_HOLD));

    // done wins over an expiring counter: that case is a normal release without timeout.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (sel_found) begin
                hold_d = '0;
            end
        end else if (!done) begin
            if (hold_expired) begin
                timeout_d = 1'b1;
            end else begin
                hold_d = hold_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 Parameter MAX_HOLD, default 255, is the maximum number of cycles a grant may be held before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  16  request vector; bit i high means requester i wants the shared resource.
REQ-005 done  input  1  current grant holder releases the resource; sampled only in GRANT.
REQ-006 grant  output  16  registered one-hot grant, all-zero when idle; bit i equals decode of grant_idx gated by busy.
REQ-007 grant_idx  output  4  binary index of the current or most recent grantee.
REQ-008 busy  output  1  high while a grant is active.
REQ-009 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 The state machine SHALL have exactly two states: IDLE and GRANT.
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with grant == 0 and busy == 0.
REQ-012 In IDLE with req != 0, the block SHALL select the first set bit of req, searching upward from pointer ptr and wrapping from 15 to 0.
REQ-013 On the edge after selection, grant_idx SHALL load the selected index, grant SHALL become its one-hot decode, busy SHALL go high, and the state SHALL become GRANT (req-to-grant latency of 1 cycle).
REQ-014 In GRANT, grant, grant_idx and busy SHALL hold, and req SHALL be ignored, including a drop of the holder's own req bit.
REQ-015 In GRANT with done == 1, the next edge SHALL clear grant and busy, set ptr = grant_idx + 1 mod 16, and return to IDLE.
REQ-016 Because of REQ-015, there SHALL be at least one cycle with grant == 0 between two consecutive grants.
REQ-017 grant_idx SHALL retain its last value in IDLE.
REQ-018 grant SHALL never have more than one bit set.
REQ-019 done asserted in IDLE SHALL have no effect.
REQ-020 ptr SHALL be 4 bits wide and wrap naturally, so that 15 + 1 gives 0.
REQ-021 Fairness: with all 16 requests held continuously, each requester SHALL receive exactly one grant per 16 grants, in ascending order starting at ptr.

Reset
REQ-022 While rst_n == 0, the block SHALL immediately force the following values, independent of clk:
- state = IDLE
- ptr = 0
- grant = 0
- grant_idx = 0
- busy = 0
- timeout = 0
- hold counter = 0
REQ-023 Reset asserted during GRANT SHALL abort the grant, and the first arbitration after release SHALL start from ptr = 0.
REQ-024 The first active edge after rst_n rises SHALL be allowed to evaluate req normally.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined, an 8-bit or wider hold counter SHALL clear on entry to GRANT and increment on every GRANT cycle with done == 0.
REQ-026 With ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD without done, the next edge SHALL release exactly as in REQ-015, and timeout SHALL be high for that one cycle.
REQ-027 With ARB_TIMEOUT_EN defined, done and the timeout condition occurring in the same cycle SHALL cause a normal release with timeout == 0.
REQ-028 Without ARB_TIMEOUT_EN, the counter logic SHALL be absent, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely until done.

Verification
REQ-029 Reset, then req = 16'h0001 -> one cycle later grant = 16'h0001, grant_idx = 0, busy = 1; done pulse -> grant = 0 on the next cycle, ptr = 1.
REQ-030 req = 16'hFFFF held, done pulsed once per grant -> grant_idx sequence 0,1,2,...,15,0 with one idle cycle between grants.
REQ-031 ptr = 5 (after granting 4), req = 16'h0011 -> grant_idx = 0 and grant = 16'h0001 (wrap past 15), since bits 5..15 are clear.
REQ-032 Grant holder 3 drops req while done == 0 for 10 cycles -> grant stays 16'h0008; done -> release.
REQ-033 With ARB_TIMEOUT_EN and MAX_HOLD = 4, grant with done == 0 -> release after the counter reaches 4, timeout pulses for 1 cycle, next requester granted; without the macro, grant persists for 100 or more cycles and timeout stays 0.
REQ-034 rst_n pulsed low mid-GRANT (grant_idx = 9) -> grant = 0 and busy = 0 asynchronously; req = 16'hFFFF then -> grant_idx = 0.
